// File: rtl/aq_djpeg_bitstream.sv
// JPEG entropy-data front end: unpacks stream words byte by byte, strips FF00 stuffing
// and markers in image mode, and serves an MSB-aligned bit window to the Huffman decoder.
module aq_djpeg_bitstream #(
    parameter int IN_BYTES = 4,
    parameter int WIN_BITS = 96,
    parameter int OUT_BITS = 32,
    localparam int CW = $clog2(WIN_BITS + 1),
    localparam int UW = $clog2(OUT_BITS + 1),
    localparam int IW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*IN_BYTES-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  image_enable,
    input  logic                  clear,
    output logic [OUT_BITS-1:0]   dout,
    output logic [CW-1:0]         dout_count,
    output logic                  dout_valid,
    input  logic                  use_bit,
    input  logic [UW-1:0]         use_width,
    input  logic                  use_align,
    output logic                  rst_marker,
    output logic [2:0]            rst_index,
    output logic                  data_end,
    output logic                  marker_err,
    output logic                  underflow
);

    logic [WIN_BITS-1:0]      win, win_c, win_n, push_ext;
    logic [CW-1:0]            count, count_c, count_n, w;
    logic [IN_BYTES-1:0][7:0] word;
    logic                     full, pending_ff;
    logic [IW-1:0]            idx;

    logic [7:0] cur, push_byte;
    logic       do_push, pend_n, is_rst, is_err, is_eoi;
    logic       under, stall, proc, last, word_done, push_now;

    // Consume first; the incoming byte lands behind whatever survives the shift.
    always_comb begin
        w = '0;
        if (use_bit)        w = CW'(use_width);
        else if (use_align) w = CW'(count[2:0]);
    end

    assign under   = (w > count);
    assign count_c = under ? '0 : count - w;
    assign win_c   = under ? '0 : win << w;

    assign cur = word[idx];

    always_comb begin
        do_push   = 1'b0;
        push_byte = cur;
        pend_n    = pending_ff;
        is_rst    = 1'b0;
        is_err    = 1'b0;
        is_eoi    = 1'b0;
        if (!image_enable) begin
            do_push = 1'b1;
            pend_n  = 1'b0;
        end else if (!pending_ff) begin
            if (cur == 8'hFF) pend_n  = 1'b1;
            else              do_push = 1'b1;
        end else if (cur == 8'h00) begin
            do_push   = 1'b1;
            push_byte = 8'hFF;
            pend_n    = 1'b0;
        end else if (cur == 8'hFF) begin
            pend_n = 1'b1;
        end else if (cur[7:3] == 5'b11010) begin
            is_rst = 1'b1;
            pend_n = 1'b0;
        end else if (cur == 8'hD9) begin
            is_eoi = 1'b1;
            pend_n = 1'b0;
        end else begin
            is_err = 1'b1;
            pend_n = 1'b0;
        end
    end

    assign stall     = do_push & (count_c > CW'(WIN_BITS - 8));
    assign proc      = full & ~data_end & ~stall;
    assign last      = (idx == IW'(IN_BYTES - 1));
    assign word_done = proc & (last | is_eoi);
    // EOI in the current byte must not let a following word slip in.
    assign din_ready = (~full | (proc & last & ~is_eoi)) & ~data_end;

    assign push_now = proc & do_push;
    assign push_ext = {push_byte, {(WIN_BITS-8){1'b0}}};
    assign win_n    = win_c | (push_now ? (push_ext >> count_c) : '0);
    assign count_n  = count_c + (push_now ? CW'(8) : CW'(0));

    assign dout       = win[WIN_BITS-1 -: OUT_BITS];
    assign dout_count = count;
    assign dout_valid = (count >= CW'(OUT_BITS)) | (data_end & (count != '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win        <= '0;
            count      <= '0;
            word       <= '0;
            full       <= 1'b0;
            idx        <= '0;
            pending_ff <= 1'b0;
            rst_marker <= 1'b0;
            rst_index  <= '0;
            data_end   <= 1'b0;
            marker_err <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            win        <= '0;
            count      <= '0;
            word       <= '0;
            full       <= 1'b0;
            idx        <= '0;
            pending_ff <= 1'b0;
            rst_marker <= 1'b0;
            rst_index  <= '0;
            data_end   <= 1'b0;
            marker_err <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            win        <= win_n;
            count      <= count_n;
            rst_marker <= proc & is_rst;
            marker_err <= proc & is_err;
            if (under)         underflow  <= 1'b1;
            if (proc & is_rst) rst_index  <= cur[2:0];
            if (proc & is_eoi) data_end   <= 1'b1;
            if (proc)          pending_ff <= pend_n;
            if (din_valid & din_ready) begin
                word <= din;
                full <= 1'b1;
                idx  <= '0;
            end else if (word_done) begin
                full <= 1'b0;
                idx  <= '0;
            end else if (proc) begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_aq_djpeg_bitstream.sv
// Directed bench for aq_djpeg_bitstream: one task per scenario with hand-computed expectations.
module tb_aq_djpeg_bitstream;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] din;
    logic        din_valid, din_ready, image_enable, clear;
    logic [31:0] dout;
    logic [6:0]  dout_count;
    logic        dout_valid, use_bit, use_align;
    logic [5:0]  use_width;
    logic        rst_marker, data_end, marker_err, underflow;
    logic [2:0]  rst_index;

    int tests = 0;
    int fails = 0;
    int n_rst = 0;
    int n_err = 0;

    aq_djpeg_bitstream #(.IN_BYTES(4), .WIN_BITS(96), .OUT_BITS(32)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .image_enable(image_enable), .clear(clear), .dout(dout), .dout_count(dout_count),
        .dout_valid(dout_valid), .use_bit(use_bit), .use_width(use_width), .use_align(use_align),
        .rst_marker(rst_marker), .rst_index(rst_index), .data_end(data_end),
        .marker_err(marker_err), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_marker) n_rst++;
        if (marker_err) n_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_clear();
        step(); clear = 1'b1;
        step(); clear = 1'b0;
        n_rst = 0; n_err = 0;
    endtask

    task automatic send_word(input logic [31:0] v);
        int n;
        step();
        din = v; din_valid = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (din_ready) break;
        end
        tests++;
        if (n == 100) begin
            fails++; $display("FAIL send_word timeout got ready=%b exp 1", din_ready);
        end
        step(); din_valid = 1'b0;
    endtask

    task automatic consume(input int wd);
        step(); use_bit = 1'b1; use_width = 6'(wd);
        step(); use_bit = 1'b0;
    endtask

    task automatic align();
        step(); use_align = 1'b1;
        step(); use_align = 1'b0;
    endtask

    task automatic wait_count(input int c);
        int n;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (dout_count == 7'(c)) break;
        end
        tests++;
        if (n == 60) begin
            fails++; $display("FAIL wait_count got %0d exp %0d", dout_count, c);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({din_ready, dout, dout_count, dout_valid, rst_marker, rst_index, data_end, marker_err, underflow}
            !== {1'b1, 32'h0, 7'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset_hold got dout=%h cnt=%0d rdy=%b exp dout=0 cnt=0 rdy=1", dout, dout_count, din_ready);
        end
        step(); rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({din_ready, dout_count, dout_valid, data_end, underflow} !== {1'b1, 7'd0, 1'b0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL reset_release got cnt=%0d rdy=%b exp cnt=0 rdy=1", dout_count, din_ready);
        end
    endtask

    task automatic test_basic();
        do_clear();
        send_word(32'h44332211);
        send_word(32'h88776655);
        wait_count(64);
        tests++;
        if (dout !== 32'h11223344 || dout_valid !== 1'b1) begin
            fails++; $display("FAIL basic_first got %h v=%b exp 11223344 v=1", dout, dout_valid);
        end
        consume(32);
        @(negedge clk);
        tests++;
        if (dout !== 32'h55667788 || dout_count !== 7'd32) begin
            fails++; $display("FAIL basic_second got %h cnt=%0d exp 55667788 cnt=32", dout, dout_count);
        end
        consume(32);
        @(negedge clk);
        tests++;
        if (dout_count !== 7'd0 || dout_valid !== 1'b0) begin
            fails++; $display("FAIL basic_empty got cnt=%0d v=%b exp cnt=0 v=0", dout_count, dout_valid);
        end
        tests++;
        if (n_rst != 0 || n_err != 0 || data_end !== 1'b0 || underflow !== 1'b0) begin
            fails++; $display("FAIL basic_flags got rst=%0d err=%0d end=%b uf=%b exp all 0", n_rst, n_err, data_end, underflow);
        end
    endtask

    task automatic test_stuffing();
        do_clear();
        send_word(32'h3400FF12);
        send_word(32'hFFFFFF56);
        wait_count(32);
        repeat (4) step();
        @(negedge clk);
        tests++;
        if (dout !== 32'h12FF3456 || dout_count !== 7'd32) begin
            fails++; $display("FAIL stuffing got %h cnt=%0d exp 12ff3456 cnt=32", dout, dout_count);
        end
    endtask

    task automatic test_restart();
        do_clear();
        send_word(32'hD3FFFFAB);
        send_word(32'hFF55FFCD);
        wait_count(16);
        repeat (4) step();
        @(negedge clk);
        tests++;
        if (n_rst != 1 || rst_index !== 3'd3) begin
            fails++; $display("FAIL restart_marker got pulses=%0d idx=%0d exp pulses=1 idx=3", n_rst, rst_index);
        end
        tests++;
        if (n_err != 1) begin
            fails++; $display("FAIL restart_illegal got pulses=%0d exp 1", n_err);
        end
        tests++;
        if (dout !== 32'hABCD0000 || dout_count !== 7'd16) begin
            fails++; $display("FAIL restart_window got %h cnt=%0d exp abcd0000 cnt=16", dout, dout_count);
        end
        consume(3);
        @(negedge clk);
        tests++;
        if (dout !== 32'h5E680000 || dout_count !== 7'd13) begin
            fails++; $display("FAIL restart_partial got %h cnt=%0d exp 5e680000 cnt=13", dout, dout_count);
        end
        align();
        @(negedge clk);
        tests++;
        if (dout !== 32'hCD000000 || dout_count !== 7'd8) begin
            fails++; $display("FAIL restart_align got %h cnt=%0d exp cd000000 cnt=8", dout, dout_count);
        end
    endtask

    task automatic test_eoi();
        int n;
        do_clear();
        send_word(32'h77D9FF01);
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (data_end) break;
        end
        tests++;
        if (data_end !== 1'b1) begin
            fails++; $display("FAIL eoi_seen got %b exp 1", data_end);
        end
        step(); din = 32'h12345678; din_valid = 1'b1;
        repeat (3) step();
        @(negedge clk);
        tests++;
        if (din_ready !== 1'b0 || data_end !== 1'b1) begin
            fails++; $display("FAIL eoi_ready got rdy=%b end=%b exp rdy=0 end=1", din_ready, data_end);
        end
        tests++;
        if (dout !== 32'h01000000 || dout_count !== 7'd8 || dout_valid !== 1'b1) begin
            fails++; $display("FAIL eoi_tail got %h cnt=%0d v=%b exp 01000000 cnt=8 v=1", dout, dout_count, dout_valid);
        end
        step(); din_valid = 1'b0;
    endtask

    task automatic test_header();
        do_clear();
        image_enable = 1'b0;
        send_word(32'hD9FF00FF);
        wait_count(32);
        repeat (2) step();
        @(negedge clk);
        tests++;
        if (dout !== 32'hFF00FFD9 || dout_count !== 7'd32 || data_end !== 1'b0 || n_rst != 0) begin
            fails++; $display("FAIL header_raw got %h cnt=%0d end=%b exp ff00ffd9 cnt=32 end=0", dout, dout_count, data_end);
        end
        image_enable = 1'b1;
    endtask

    task automatic test_back_to_back_stall();
        do_clear();
        send_word(32'h04030201);
        send_word(32'h08070605);
        send_word(32'h0C0B0A09);
        send_word(32'h100F0E0D);
        wait_count(96);
        repeat (3) step();
        @(negedge clk);
        tests++;
        if (dout_count !== 7'd96 || din_ready !== 1'b0 || dout !== 32'h01020304) begin
            fails++; $display("FAIL stall_full got cnt=%0d rdy=%b dout=%h exp cnt=96 rdy=0 dout=01020304", dout_count, din_ready, dout);
        end
        consume(5);
        @(negedge clk);
        tests++;
        if (dout_count !== 7'd91) begin
            fails++; $display("FAIL stall_hold got cnt=%0d exp 91", dout_count);
        end
        consume(5);
        @(negedge clk);
        tests++;
        if (dout_count !== 7'd94 || dout !== 32'h080C1014) begin
            fails++; $display("FAIL stall_land got cnt=%0d dout=%h exp cnt=94 dout=080c1014", dout_count, dout);
        end
    endtask

    task automatic test_underflow();
        do_clear();
        send_word(32'hFFFFFFAA);
        wait_count(8);
        consume(2);
        @(negedge clk);
        tests++;
        if (dout_count !== 7'd6 || underflow !== 1'b0) begin
            fails++; $display("FAIL under_pre got cnt=%0d uf=%b exp cnt=6 uf=0", dout_count, underflow);
        end
        consume(10);
        @(negedge clk);
        tests++;
        if (dout_count !== 7'd0 || underflow !== 1'b1 || dout !== 32'h0) begin
            fails++; $display("FAIL under_hit got cnt=%0d uf=%b dout=%h exp cnt=0 uf=1 dout=0", dout_count, underflow, dout);
        end
        step();
        @(negedge clk);
        tests++;
        if (underflow !== 1'b1) begin
            fails++; $display("FAIL under_sticky got %b exp 1", underflow);
        end
    endtask

    task automatic test_clear();
        send_word(32'h44332211);
        @(negedge clk);
        step(); clear = 1'b1;
        step(); clear = 1'b0;
        @(negedge clk);
        tests++;
        if ({din_ready, dout, dout_count, dout_valid, rst_index, data_end, underflow}
            !== {1'b1, 32'h0, 7'd0, 1'b0, 3'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL clear_state got dout=%h cnt=%0d rdy=%b uf=%b exp 0/0/1/0", dout, dout_count, din_ready, underflow);
        end
        repeat (5) step();
        @(negedge clk);
        tests++;
        if (dout_count !== 7'd0) begin
            fails++; $display("FAIL clear_flush got cnt=%0d exp 0", dout_count);
        end
    endtask

    initial begin
        din = '0; din_valid = 1'b0; image_enable = 1'b1; clear = 1'b0;
        use_bit = 1'b0; use_width = '0; use_align = 1'b0;
        test_reset();
        test_basic();
        test_stuffing();
        test_restart();
        test_eoi();
        test_header();
        test_back_to_back_stall();
        test_underflow();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aq_djpeg_bitstream.md
Name: aq_djpeg_bitstream

Overview:
- Parametrised successor to the JPEG entropy-data register stage.
- Accepts packed compressed-stream words and unpacks them one byte per cycle.
- In image mode: removes 0xFF00 byte stuffing, strips fill bytes, detects RST0-7 and EOI markers.
- Keeps an MSB-aligned bit window, presents the top OUT_BITS to the Huffman decoder, and supports variable-width consume plus byte-align for restart intervals.

Parameters:
IN_BYTES, 4, bytes per input word; byte 0 = din[7:0] is first in stream order.
WIN_BITS, 96, bit-window depth; multiple of 8, >= OUT_BITS+8.
OUT_BITS, 32, width of peek output and maximum single consume.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-low reset.
din  in  8*IN_BYTES  packed stream word.
din_valid  in  1  din holds a word.
din_ready  out  1  word accepted when din_valid & din_ready.
image_enable  in  1  1 = entropy-coded segment (unstuff and detect markers); 0 = header mode (raw bytes).
clear  in  1  synchronous flush of all state.
dout  out  OUT_BITS  next stream bits, MSB = oldest; bits beyond dout_count read 0.
dout_count  out  clog2(WIN_BITS+1)  valid bits in window.
dout_valid  out  1  dout_count >= OUT_BITS, or data_end & dout_count > 0.
use_bit  in  1  consume use_width bits.
use_width  in  clog2(OUT_BITS+1)  bits to consume, 1..OUT_BITS.
use_align  in  1  discard dout_count mod 8 bits.
rst_marker  out  1  one-cycle pulse on RSTn.
rst_index  out  3  n of last RSTn.
data_end  out  1  EOI (FFD9) seen; sticky until clear.
marker_err  out  1  one-cycle pulse: FF followed by an illegal code in image mode.
underflow  out  1  sticky: consume exceeded dout_count.

Behaviour:
- Reset/clear: window=0, count=0, word register empty, pending_ff=0, byte index=0. Outputs: din_ready=1, dout=0, dout_count=0, dout_valid=0, rst_marker=0, rst_index=0, data_end=0, marker_err=0, underflow=0. clear has priority over all other inputs in the same cycle.
- Word register:
  - din_ready = (register empty, or last byte being processed this cycle) & ~data_end.
  - Bytes are processed in index order 0..IN_BYTES-1, at most one per cycle.
  - A byte stalls (index holds) when it would push and count > WIN_BITS-8 after this cycle's consume.
- Byte rules, image_enable=1:
  - pending_ff=0, b!=FF: push b.
  - pending_ff=0, b==FF: set pending_ff; no push.
  - pending_ff=1, b==00: push FF; clear pending_ff.
  - pending_ff=1, b==FF: fill byte; pending_ff stays set; no push.
  - pending_ff=1, b in D0..D7: pulse rst_marker, rst_index=b[2:0], clear pending_ff; no push.
  - pending_ff=1, b==D9: set data_end, clear pending_ff, drop remaining bytes of the word; no further input accepted.
  - pending_ff=1, any other b: pulse marker_err, clear pending_ff; no push.
- Byte rules, image_enable=0: every byte pushed raw; pending_ff forced 0.
- Mode switch: takes effect from the next byte processed. No retro-scan of bytes already in the window; header-to-image transitions happen on byte boundaries set by the header parser.
- Window:
  - Valid bits sit at win[WIN_BITS-1 -: count]; all lower bits are held 0.
  - Consume of w shifts left by w, zero-filling.
  - A push places the byte at bit positions WIN_BITS-1-(count-w) downward.
  - Push and consume in the same cycle are legal: count' = count - w + 8.
- Consume:
  - use_bit: w=use_width. use_align: w=count mod 8. Neither: w=0.
  - use_bit and use_align together: use_bit wins.
  - w > count: count goes to 0, underflow set.
- Latency:
  - dout, dout_count and dout_valid are registered window state; no combinational path from any input.
  - A pushed byte is visible in dout the cycle after it is processed.
  - A consume is reflected the next cycle.
  - Minimum din accept to first dout_valid with OUT_BITS=32: 4 byte-cycles + 1.
- After data_end: dout_valid stays high while count > 0; tail bits read as zero padding.

Test Plan:
- image_enable=1; words 0x44332211, 0x88776655 (first bytes 11,22,...); use_bit w=32 each cycle valid -> dout=0x11223344 then 0x55667788; no flags.
- Stream bytes 12 FF 00 34 56 -> window bytes 12 FF 34 56; dout_count=32; dout=0x12FF3456.
- Bytes AB FF FF D3 CD plus a partial byte; use_align when count mod 8=5 -> rst_marker pulse once, rst_index=3, 5 bits dropped, dout next holds 0xCD in its top bits.
- Bytes 01 FF D9 77 -> data_end=1 after D9; 0x77 discarded; din_ready=0; dout_valid=1 with dout=0x01000000, dout_count=8.
- image_enable=0, bytes FF 00 FF D9 -> all four bytes pushed raw; dout=0xFF00FF D9; data_end=0.
- Full window (count=96), din_valid held; use_bit w=5 together with a pending push -> byte stalls until count <= 88, then lands correctly. Separately, use_bit w=10 with count=6 -> count=0, underflow=1. clear mid-word -> all outputs return to reset values next cycle.
